// File: rtl/exe_stage_if.sv
// Execute-stage bundle: E-stage controls/operands in, EX->MEM register and stall request out.
interface exe_stage_if #(parameter int WIDTH = 32);
  logic             regWriteE, memToRegE, memWriteE, ALUSrcE, regDstE;
  logic [3:0]       ALUControlE;
  logic [1:0]       ALUOpE;
  logic [4:0]       RsE, RtE, RdE;
  logic [WIDTH-1:0] data11, data22, signImmE, resultW;
  logic [1:0]       forwardAE, forwardBE;

  logic             regWriteM, memToRegM, memWriteM;
  logic [1:0]       ALUOpM;
  logic [WIDTH-1:0] ALUOutM, writeDataM;
  logic [4:0]       writeRegM;
  logic             busyE;

  modport master (
    output regWriteE, memToRegE, memWriteE, ALUSrcE, regDstE, ALUControlE, ALUOpE,
           RsE, RtE, RdE, data11, data22, signImmE, resultW, forwardAE, forwardBE,
    input  regWriteM, memToRegM, memWriteM, ALUOpM, ALUOutM, writeDataM, writeRegM, busyE
  );

  modport slave (
    input  regWriteE, memToRegE, memWriteE, ALUSrcE, regDstE, ALUControlE, ALUOpE,
           RsE, RtE, RdE, data11, data22, signImmE, resultW, forwardAE, forwardBE,
    output regWriteM, memToRegM, memWriteM, ALUOpM, ALUOutM, writeDataM, writeRegM, busyE
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: forwarding, single-cycle ALU, iterative signed mul/div with HI/LO,
// and the EX->MEM register. All state moves on the falling clock edge.
//
// state  | meaning
// S_IDLE | no mul/div in flight; a mul/div op in E is captured here (issue cycle)
// S_RUN  | one shift-add / restoring shift-subtract step per cycle
// S_DONE | sign correction and HI/LO write-back
module exe_stage #(
  parameter int WIDTH   = 32,
  parameter int MD_ITER = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  exe_stage_if.slave ex_io
);
  localparam int CW = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_DIV  = 4'b1001;
  localparam logic [3:0] ALU_MFHI = 4'b1010;
  localparam logic [3:0] ALU_MFLO = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} md_state_e;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic             div_q, div_d, neg_q, neg_d, neg_a_q, neg_a_d, dz_q, dz_d;

  logic [WIDTH-1:0] src_a, fwd_b, src_b, a_abs, b_abs, alu_y;
  logic [4:0]       write_reg;
  logic             md_op, busy;
  logic [WIDTH:0]   mul_sum, div_shl, div_try;
  logic [2*WIDTH-1:0] product;

  logic             reg_write_m_q, mem_to_reg_m_q, mem_write_m_q;
  logic [1:0]       alu_op_m_q;
  logic [WIDTH-1:0] alu_out_m_q, write_data_m_q;
  logic [4:0]       write_reg_m_q;

  always_comb begin
    case (ex_io.forwardAE)
      2'b01:   src_a = ex_io.resultW;
      2'b10:   src_a = ex_io.ALUOutM;
      default: src_a = ex_io.data11;
    endcase
    case (ex_io.forwardBE)
      2'b01:   fwd_b = ex_io.resultW;
      2'b10:   fwd_b = ex_io.ALUOutM;
      default: fwd_b = ex_io.data22;
    endcase
    src_b     = ex_io.ALUSrcE ? ex_io.signImmE : fwd_b;
    write_reg = ex_io.regDstE ? ex_io.RdE : ex_io.RtE;
  end

  assign md_op = (ex_io.ALUControlE == ALU_MULT) || (ex_io.ALUControlE == ALU_DIV);
  assign busy  = (state_q != S_IDLE) || md_op;
  assign a_abs = src_a[WIDTH-1] ? -src_a : src_a;
  assign b_abs = fwd_b[WIDTH-1] ? -fwd_b : fwd_b;

  always_comb begin
    case (ex_io.ALUControlE)
      ALU_AND:  alu_y = src_a & src_b;
      ALU_OR:   alu_y = src_a | src_b;
      ALU_ADD:  alu_y = src_a + src_b;
      ALU_SUB:  alu_y = src_a - src_b;
      ALU_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_NOR:  alu_y = ~(src_a | src_b);
      ALU_MFHI: alu_y = hi_q;
      ALU_MFLO: alu_y = lo_q;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    b_d     = b_q;
    div_d   = div_q;
    neg_d   = neg_q;
    neg_a_d = neg_a_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_sum = {1'b0, acc_q} + {1'b0, b_q};
    div_shl = {acc_q, mq_q[WIDTH-1]};
    div_try = div_shl - {1'b0, b_q};
    product = {acc_q, mq_q};
    case (state_q)
      S_IDLE: begin
        if (md_op) begin
          acc_d   = '0;
          mq_d    = a_abs;
          b_d     = b_abs;
          div_d   = ex_io.ALUControlE[0];
          neg_d   = src_a[WIDTH-1] ^ fwd_b[WIDTH-1];
          neg_a_d = src_a[WIDTH-1];
          dz_d    = (fwd_b == '0);
          cnt_d   = CW'(MD_ITER - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (div_q) begin
          if (!div_try[WIDTH]) begin
            acc_d = div_try[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shl[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else if (mq_q[0]) begin
          {acc_d, mq_d} = {mul_sum, mq_q[WIDTH-1:1]};
        end else begin
          {acc_d, mq_d} = {1'b0, acc_q, mq_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DONE: begin
        // A zero divisor leaves |dividend| in acc, so HI already ends up as the dividend.
        if (div_q) begin
          lo_d = dz_q ? '1 : (neg_q ? -mq_q : mq_q);
          hi_d = neg_a_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_q ? -product : product;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      neg_a_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      b_q     <= b_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      neg_a_q <= neg_a_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n || busy) begin
      reg_write_m_q  <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      mem_write_m_q  <= 1'b0;
      alu_op_m_q     <= '0;
      alu_out_m_q    <= '0;
      write_data_m_q <= '0;
      write_reg_m_q  <= '0;
    end else begin
      reg_write_m_q  <= ex_io.regWriteE;
      mem_to_reg_m_q <= ex_io.memToRegE;
      mem_write_m_q  <= ex_io.memWriteE;
      alu_op_m_q     <= ex_io.ALUOpE;
      alu_out_m_q    <= alu_y;
      write_data_m_q <= fwd_b;
      write_reg_m_q  <= write_reg;
    end
  end

  assign ex_io.regWriteM  = reg_write_m_q;
  assign ex_io.memToRegM  = mem_to_reg_m_q;
  assign ex_io.memWriteM  = mem_write_m_q;
  assign ex_io.ALUOpM     = alu_op_m_q;
  assign ex_io.ALUOutM    = alu_out_m_q;
  assign ex_io.writeDataM = write_data_m_q;
  assign ex_io.writeRegM  = write_reg_m_q;
  assign ex_io.busyE      = busy;
endmodule

// File: tb/tb_exe_stage.sv
// Randomized and directed bench for exe_stage against a cycle-level arithmetic model.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exe_stage_if #(.WIDTH(32)) ex_if ();
  exe_stage #(.WIDTH(32), .MD_ITER(32)) dut (.clk(clk), .rst_n(rst_n), .ex_io(ex_if));

  int n_chk = 0;
  int n_err = 0;

  logic        m_rw, m_mtr, m_mw;
  logic [1:0]  m_aluop;
  logic [31:0] m_aluout, m_wdata, m_hi, m_lo, p_hi, p_lo;
  logic [4:0]  m_wreg;
  int          m_left;
  logic        last_busy;
  logic [31:0] spec_v [5];
  logic [3:0]  ops_v  [10];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] rf);
    case (sel)
      2'b01:   return ex_if.resultW;
      2'b10:   return m_aluout;
      default: return rf;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] code, input logic [31:0] a, b);
    case (code)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      4'd10:   return m_hi;
      4'd11:   return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic md_ref(input logic is_div, input logic [31:0] a, b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint p, q, r;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      {hi, lo} = p;
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFFFFFF;
    end else begin
      q  = longint'($signed(a)) / longint'($signed(b));
      r  = longint'($signed(a)) % longint'($signed(b));
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  task automatic model_reset();
    m_rw = 0; m_mtr = 0; m_mw = 0; m_aluop = 0;
    m_aluout = 0; m_wdata = 0; m_wreg = 0;
    m_hi = 0; m_lo = 0; m_left = 0;
  endtask

  task automatic check_m();
    chk("regWriteM",  ex_if.regWriteM,  m_rw);
    chk("memToRegM",  ex_if.memToRegM,  m_mtr);
    chk("memWriteM",  ex_if.memWriteM,  m_mw);
    chk("ALUOpM",     ex_if.ALUOpM,     m_aluop);
    chk("ALUOutM",    ex_if.ALUOutM,    m_aluout);
    chk("writeDataM", ex_if.writeDataM, m_wdata);
    chk("writeRegM",  ex_if.writeRegM,  m_wreg);
  endtask

  task automatic bubble_in();
    ex_if.regWriteE = 0; ex_if.memToRegE = 0; ex_if.memWriteE = 0;
    ex_if.ALUSrcE = 0; ex_if.regDstE = 0; ex_if.ALUControlE = 0; ex_if.ALUOpE = 0;
    ex_if.RsE = 0; ex_if.RtE = 0; ex_if.RdE = 0;
    ex_if.data11 = 0; ex_if.data22 = 0; ex_if.signImmE = 0; ex_if.resultW = 0;
    ex_if.forwardAE = 0; ex_if.forwardBE = 0;
  endtask

  // One negedge: predict busy and the EX->MEM contents, clock, then compare.
  task automatic cycle();
    logic [31:0] sa, fb, sb, n_out, n_wd;
    logic        md, eb, n_rw, n_mtr, n_mw;
    logic [1:0]  n_op;
    logic [4:0]  n_wr;
    #1;
    sa = fwd_sel(ex_if.forwardAE, ex_if.data11);
    fb = fwd_sel(ex_if.forwardBE, ex_if.data22);
    sb = ex_if.ALUSrcE ? ex_if.signImmE : fb;
    md = (ex_if.ALUControlE == 4'd8) || (ex_if.ALUControlE == 4'd9);
    eb = (m_left > 0) || md;
    last_busy = ex_if.busyE;
    chk("busyE", ex_if.busyE, eb);
    if (eb) begin
      n_rw = 0; n_mtr = 0; n_mw = 0; n_op = 0; n_out = 0; n_wd = 0; n_wr = 0;
    end else begin
      n_rw = ex_if.regWriteE; n_mtr = ex_if.memToRegE; n_mw = ex_if.memWriteE;
      n_op = ex_if.ALUOpE; n_out = alu_ref(ex_if.ALUControlE, sa, sb); n_wd = fb;
      n_wr = ex_if.regDstE ? ex_if.RdE : ex_if.RtE;
    end
    if (m_left == 0 && md) begin
      md_ref(ex_if.ALUControlE[0], sa, fb, p_hi, p_lo);
      m_left = 33;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end
    @(negedge clk);
    #1;
    m_rw = n_rw; m_mtr = n_mtr; m_mw = n_mw; m_aluop = n_op;
    m_aluout = n_out; m_wdata = n_wd; m_wreg = n_wr;
    check_m();
  endtask

  task automatic set_op(input logic [3:0] code, input logic [31:0] a, b);
    bubble_in();
    ex_if.ALUControlE = code; ex_if.data11 = a; ex_if.data22 = b;
    ex_if.regWriteE = 1; ex_if.regDstE = 1; ex_if.RdE = 5'd3;
  endtask

  task automatic run_md(input logic [3:0] code, input logic [31:0] a, b);
    int n;
    set_op(code, a, b);
    cycle();
    n = last_busy ? 1 : 0;
    bubble_in();
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (!last_busy) break;
      n++;
    end
    chk("md_stall_len", n, 34);
  endtask

  task automatic read_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    set_op(4'd11, 32'd0, 32'd0);
    cycle();
    chk("mflo", ex_if.ALUOutM, exp_lo);
    set_op(4'd10, 32'd0, 32'd0);
    cycle();
    chk("mfhi", ex_if.ALUOutM, exp_hi);
  endtask

  function automatic logic [31:0] rand_val();
    if ($urandom_range(0, 3) == 0) return spec_v[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic rand_in();
    ex_if.regWriteE = 1'($urandom); ex_if.memToRegE = 1'($urandom);
    ex_if.memWriteE = 1'($urandom); ex_if.ALUSrcE = 1'($urandom);
    ex_if.regDstE = 1'($urandom); ex_if.ALUOpE = 2'($urandom);
    ex_if.RsE = 5'($urandom); ex_if.RtE = 5'($urandom); ex_if.RdE = 5'($urandom);
    ex_if.data11 = rand_val(); ex_if.data22 = rand_val();
    ex_if.signImmE = rand_val(); ex_if.resultW = rand_val();
    ex_if.forwardAE = 2'($urandom); ex_if.forwardBE = 2'($urandom);
    if (m_left == 0 && $urandom_range(0, 7) == 0)
      ex_if.ALUControlE = ($urandom_range(0, 1) == 0) ? 4'd8 : 4'd9;
    else
      ex_if.ALUControlE = ops_v[$urandom_range(0, 9)];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    spec_v = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    ops_v  = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd10, 4'd11, 4'd3, 4'd15};
    rst_n = 0;
    bubble_in();
    model_reset();
    #3;
    check_m();
    chk("busy_reset", ex_if.busyE, 0);
    @(posedge clk);
    rst_n = 1;

    // ADD with and without forwarding
    set_op(4'd2, 32'd5, 32'd7);
    ex_if.RdE = 5'd9;
    cycle();
    chk("add_out", ex_if.ALUOutM, 12);
    chk("add_wreg", ex_if.writeRegM, 9);
    chk("add_rw", ex_if.regWriteM, 1);
    ex_if.forwardAE = 2'b01; ex_if.resultW = 32'd100;
    cycle();
    chk("add_fwdW", ex_if.ALUOutM, 107);

    // SLT / SUB on -1 vs 1
    set_op(4'd7, 32'hFFFFFFFF, 32'd1);
    cycle();
    chk("slt", ex_if.ALUOutM, 1);
    set_op(4'd6, 32'hFFFFFFFF, 32'd1);
    cycle();
    chk("sub", ex_if.ALUOutM, 32'hFFFFFFFE);

    // store data forwarded from ALUOutM
    set_op(4'd2, 32'h0000ABCD, 32'd0);
    cycle();
    bubble_in();
    ex_if.ALUControlE = 4'd2; ex_if.memWriteE = 1; ex_if.forwardBE = 2'b10;
    ex_if.ALUSrcE = 1; ex_if.signImmE = 32'd4; ex_if.data11 = 32'h100;
    cycle();
    chk("store_wdata", ex_if.writeDataM, 32'hABCD);
    chk("store_addr", ex_if.ALUOutM, 32'h104);
    chk("store_mw", ex_if.memWriteM, 1);

    run_md(4'd8, -32'sd3, 32'd7);
    read_hilo(32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md(4'd9, -32'sd17, 32'd5);
    read_hilo(32'hFFFFFFFE, 32'hFFFFFFFD);
    run_md(4'd9, 32'd7, 32'd0);
    read_hilo(32'd7, 32'hFFFFFFFF);
    run_md(4'd9, 32'h80000000, 32'hFFFFFFFF);
    read_hilo(32'd0, 32'h80000000);
    run_md(4'd9, -32'sd9, 32'd0);
    read_hilo(32'hFFFFFFF7, 32'hFFFFFFFF);

    // reset in the middle of a MULT
    set_op(4'd8, 32'h12345678, 32'h9ABCDEF);
    cycle();
    bubble_in();
    for (int i = 0; i < 10; i++) cycle();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_m();
    chk("busy_rst_bubble", ex_if.busyE, 0);
    ex_if.ALUControlE = 4'd8;
    #1;
    chk("busy_rst_mdop", ex_if.busyE, 1);
    ex_if.ALUControlE = 4'd0;
    @(posedge clk);
    rst_n = 1;
    set_op(4'd10, 32'd0, 32'd0);
    cycle();
    chk("mfhi_after_rst", ex_if.ALUOutM, 0);

    for (int i = 0; i < 600; i++) begin
      rand_in();
      cycle();
    end
    bubble_in();
    for (int i = 0; i < 40 && m_left > 0; i++) cycle();
    read_hilo(m_hi, m_lo);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
